// File: rtl/lsu_bus.sv
// lsu_bus: one-at-a-time RV32 load/store unit on a request/grant + response
// data-memory bus, with lane steering, load extension and precise exceptions.
module lsu_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          STORE_ACK      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data,
  output logic        st_done,
  output logic        exc_valid,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic        d_req,
  output logic        d_we,
  output logic [3:0]  d_be,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  input  logic        d_gnt,
  input  logic        d_rvalid,
  input  logic [31:0] d_rdata,
  input  logic        d_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

  state_t      state;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [4:0]  op_rd;
  logic [31:0] op_ea;
  logic [31:0] wait_cnt;

  logic [31:0] ea;
  logic [31:0] cnt_next;
  logic        timed_out;
  logic        is_illegal;
  logic        is_misaligned;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // RESP is treated like IDLE for acceptance so requests can issue back-to-back
  assign req_ready = (state == IDLE) || (state == RESP);
  assign busy      = (state == REQ) || (state == WAIT);

  assign ea        = req_base + req_offset;
  assign cnt_next  = wait_cnt + 32'd1;
  // >= rather than == so a grant in the last REQ cycle still times out in WAIT
  assign timed_out = (TIMEOUT_LIMIT != 32'd0) && (cnt_next >= TIMEOUT_LIMIT);

  // Classify the incoming request: unsupported funct3 or unaligned address
  always_comb begin
    is_illegal    = 1'b0;
    is_misaligned = 1'b0;
    if (req_store) begin
      is_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      is_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    case (req_funct3[1:0])
      2'b01:   is_misaligned = ea[0];
      2'b10:   is_misaligned = (ea[1:0] != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated write data for the incoming request
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = 32'h0;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          store_be    = 4'b0001 << ea[1:0];
          store_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          store_be    = 4'b0011 << ea[1:0];
          store_wdata = {2{req_wdata[15:0]}};
        end
        default: store_wdata = req_wdata;
      endcase
    end
  end

  // Move the addressed lane down to bit 0 and extend it to 32 bits
  assign rdata_shifted = d_rdata >> {op_ea[1:0], 3'b000};

  always_comb begin
    case (op_funct3)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Access sequencer: accept, drive the bus, collect the response, pulse one result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_store  <= 1'b0;
      op_funct3 <= 3'b000;
      op_rd     <= 5'd0;
      op_ea     <= 32'h0;
      wait_cnt  <= 32'h0;
      ld_valid  <= 1'b0;
      ld_rd     <= 5'd0;
      ld_data   <= 32'h0;
      st_done   <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 4'd0;
      exc_addr  <= 32'h0;
      d_req     <= 1'b0;
      d_we      <= 1'b0;
      d_be      <= 4'b0000;
      d_addr    <= 32'h0;
      d_wdata   <= 32'h0;
    end else begin
      ld_valid  <= 1'b0;
      st_done   <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (req_valid) begin
            op_store  <= req_store;
            op_funct3 <= req_funct3;
            op_rd     <= req_rd;
            op_ea     <= ea;
            if (is_illegal) begin
              state     <= RESP;
              exc_valid <= 1'b1;
              exc_cause <= 4'd2;
              exc_addr  <= ea;
            end else if (is_misaligned) begin
              state     <= RESP;
              exc_valid <= 1'b1;
              exc_cause <= req_store ? 4'd6 : 4'd4;
              exc_addr  <= ea;
            end else begin
              state    <= REQ;
              wait_cnt <= 32'h0;
              d_req    <= 1'b1;
              d_we     <= req_store;
              d_be     <= store_be;
              d_addr   <= {ea[31:2], 2'b00};
              d_wdata  <= store_wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          wait_cnt <= cnt_next;
          if (d_gnt) begin
            d_req <= 1'b0;
            if (op_store && !STORE_ACK) begin
              state   <= RESP;
              st_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (timed_out) begin
            d_req     <= 1'b0;
            state     <= RESP;
            exc_valid <= 1'b1;
            exc_cause <= op_store ? 4'd7 : 4'd5;
            exc_addr  <= op_ea;
          end
        end
        WAIT: begin
          wait_cnt <= cnt_next;
          if (d_rvalid) begin
            state <= RESP;
            if (d_err) begin
              exc_valid <= 1'b1;
              exc_cause <= op_store ? 4'd7 : 4'd5;
              exc_addr  <= op_ea;
            end else if (op_store) begin
              st_done <= 1'b1;
            end else begin
              ld_valid <= 1'b1;
              ld_rd    <= op_rd;
              ld_data  <= load_ext;
            end
          end else if (timed_out) begin
            state     <= RESP;
            exc_valid <= 1'b1;
            exc_cause <= op_store ? 4'd7 : 4'd5;
            exc_addr  <= op_ea;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
